vga_frame_capture_ctl: RTL and testbench
========================================

Name: vga_frame_capture_ctl

Overview:
Synthesizable sequencer that arms and paces frame capture from the VGA timing/pixel stream for the frame-dump sink. It measures active frame size, then drives the sink's `go` frame-boundary strobe, `xdim`/`ydim` and a gated, pipelined pixel stream for N consecutive frames. It sits at the output of the VGA pipeline, in parallel with the display path, on the pixel clock.

Parameters:
- CNT_W, 16, width of the dimension counters, `xdim` and `ydim`.
- FRM_W, 8, width of `num_frames` and `frame_idx`.

Ports:
- pclk  in  1  pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle capture request.
- num_frames  in  FRM_W  frames to capture; sampled on accepted `start`.
- vblnk  in  1  vertical blank from the timing chain.
- hblnk  in  1  horizontal blank from the timing chain.
- r_in, g_in, b_in  in  8 each  pixel colour, aligned with the blanks.
- go  out  1  one-cycle frame-boundary strobe to the sink.
- wr_en  out  1  valid qualifier for `r_out`/`g_out`/`b_out`.
- r_out, g_out, b_out  out  8 each  registered pixel data.
- xdim, ydim  out  CNT_W  measured active width and height.
- frame_idx  out  FRM_W  index of the frame currently being captured.
- busy  out  1  high from accepted `start` until `done`.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared on accepted `start`.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-operation aborts immediately and emits no closing `go`.
- Edge detect uses `vblnk_q`/`hblnk_q` (registered copies).
  - vfall = `vblnk_q & !vblnk`.
  - vrise = `!vblnk_q & vblnk`.
  - active = `!vblnk & !hblnk`.
- FSM states: IDLE, SYNC, MEASURE, ARM, CAPTURE, FINISH.
- IDLE:
  - `start` is accepted only here; it is ignored in every other state.
  - On accept: latch `num_frames`, clear `err`, `frame_idx` := 0, `busy` := 1.
  - If `num_frames` == 0: go to FINISH without any `go` pulse, so `done` asserts the next cycle.
  - Otherwise go to SYNC.
- SYNC: wait for vfall, then go to MEASURE. A start issued mid-frame therefore never measures a partial frame.
- MEASURE:
  - Entered on the vfall cycle; that cycle and all following cycles up to, but not including, vrise are counted.
  - `xdim` = active-pixel count of the first line that contains any active pixel.
  - `ydim` = number of lines containing at least one active pixel.
  - Both counters saturate at all-ones.
  - On vrise: if `xdim` == 0 or `ydim` == 0, set `err` and go to FINISH with no `go` pulse. Otherwise go to ARM.
  - `xdim`/`ydim` are held constant from here until the next accepted `start`.
- ARM: on vfall go to CAPTURE, and pulse `go` = 1 in the following cycle.
- CAPTURE:
  - Data path: `wr_en`, `r_out`, `g_out` and `b_out` have 2-cycle latency from inputs sampled while active.
    - Result: `go` always precedes the first `wr_en` of a frame by at least 1 cycle.
  - Line check: per-line active counter compared with `xdim` at each line end (hblnk rise within the active region). Mismatch sets `err` (sticky); capture continues.
  - On vrise:
    - Increment `frame_idx`.
    - If `frame_idx`+1 == latched N: go to FINISH and pulse `go` once more (closing pulse), 1 cycle after the vrise detect.
    - Otherwise return to ARM.
  - Consequence: N captured frames produce exactly N+1 `go` pulses.
- FINISH: assert `done` for exactly 1 cycle, the same cycle as the closing `go`. Drop `busy` in that cycle, then go to IDLE.
- Pipeline flush: `wr_en` for pixels already in flight at a state exit still drains (2 cycles), except on reset.
- `go` is never asserted in two consecutive cycles.
- `frame_idx` wraps modulo 2^FRM_W; N up to 2^FRM_W−1 is supported.

Test Plan:
- Synthetic timing, 12x6 total, 8x4 active; `start` with `num_frames`=2 → `xdim`=8, `ydim`=4, exactly 3 `go` pulses, 64 `wr_en` cycles whose data matches input delayed by 2, `done` once, `err`=0, `busy` low after `done`.
- `num_frames`=0 → `done` 1 cycle after FINISH entry, `busy` high for exactly 2 cycles, no `go`, no `wr_en`.
- `start` asserted mid-active-region and again during CAPTURE → capture waits for the next vfall to measure, the second `start` is ignored, and the total frames captured equals the first request.
- Assert `rst` midway through the second frame → all outputs 0 on the next edge, and no further `go`, `wr_en` or `done` until a new `start`.
- Shorten one captured line to 7 active pixels → `err`=1 from that line's end onward, the capture still completes with 3 `go` pulses, and `err` clears on the next accepted `start`.
- `hblnk` held high for a whole frame (no active pixels) → `err`=1, `done` pulses, no `go` ever asserted.

Source files
------------

// File: rtl/vga_frame_capture_ctl_if.sv
// Bus between the VGA pipeline tap, the frame-capture sequencer and the frame-dump sink.
// The master side drives the timing/pixel stream and requests; the slave side is the sequencer.
interface vga_frame_capture_ctl_if #(
   parameter int CNT_W = 16,
   parameter int FRM_W = 8
);
   logic             start;
   logic [FRM_W-1:0] num_frames;
   logic             vblnk;
   logic             hblnk;
   logic [7:0]       r_in;
   logic [7:0]       g_in;
   logic [7:0]       b_in;
   logic             go;
   logic             wr_en;
   logic [7:0]       r_out;
   logic [7:0]       g_out;
   logic [7:0]       b_out;
   logic [CNT_W-1:0] xdim;
   logic [CNT_W-1:0] ydim;
   logic [FRM_W-1:0] frame_idx;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, num_frames, vblnk, hblnk, r_in, g_in, b_in,
      input  go, wr_en, r_out, g_out, b_out, xdim, ydim, frame_idx, busy, done, err
   );

   modport slave (
      input  start, num_frames, vblnk, hblnk, r_in, g_in, b_in,
      output go, wr_en, r_out, g_out, b_out, xdim, ydim, frame_idx, busy, done, err
   );
endinterface

// File: rtl/vga_frame_capture_ctl.sv
// Frame-capture sequencer: measures the active frame size, then paces N frames of
// pixels to the frame-dump sink with go strobes and a 2-cycle pixel pipeline.
module vga_frame_capture_ctl #(
   parameter int CNT_W = 16,
   parameter int FRM_W = 8
) (
   input  logic                   pclk,
   input  logic                   rst,
   vga_frame_capture_ctl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, SYNC, MEASURE, ARM, CAPTURE, FINISH} state_t;

   state_t           state;
   logic             vblnk_q;
   logic             hblnk_q;
   logic             vfall;
   logic             vrise;
   logic             active;
   logic             line_end;
   logic             cap_en;
   logic [CNT_W-1:0] line_cnt;
   logic [CNT_W-1:0] xdim;
   logic [CNT_W-1:0] ydim;
   logic             x_lock;
   logic [FRM_W-1:0] n_lat;
   logic [FRM_W-1:0] frame_idx;
   logic [FRM_W-1:0] frame_nxt;
   logic             go;
   logic             done;
   logic             busy;
   logic             err;
   logic             p_v;
   logic [7:0]       p_r;
   logic [7:0]       p_g;
   logic [7:0]       p_b;
   logic             wr_en;
   logic [7:0]       r_out;
   logic [7:0]       g_out;
   logic [7:0]       b_out;

   always_comb begin
      vfall     = vblnk_q & ~bus.vblnk;
      vrise     = ~vblnk_q & bus.vblnk;
      active    = ~bus.vblnk & ~bus.hblnk;
      line_end  = bus.hblnk & ~hblnk_q & ~bus.vblnk;
      frame_nxt = frame_idx + 1'b1;
      // The vfall cycle that leaves ARM already carries the first pixel of the frame.
      cap_en    = active & ((state == CAPTURE) | ((state == ARM) & vfall));
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         vblnk_q  <= 1'b0;
         hblnk_q  <= 1'b0;
         line_cnt <= '0;
         p_v      <= 1'b0;
         p_r      <= '0;
         p_g      <= '0;
         p_b      <= '0;
         wr_en    <= 1'b0;
         r_out    <= '0;
         g_out    <= '0;
         b_out    <= '0;
      end else begin
         vblnk_q <= bus.vblnk;
         hblnk_q <= bus.hblnk;
         if (active)
            line_cnt <= (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;
         else if (bus.hblnk)
            line_cnt <= '0;
         p_v   <= cap_en;
         p_r   <= bus.r_in;
         p_g   <= bus.g_in;
         p_b   <= bus.b_in;
         wr_en <= p_v;
         r_out <= p_r;
         g_out <= p_g;
         b_out <= p_b;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state     <= IDLE;
         n_lat     <= '0;
         frame_idx <= '0;
         xdim      <= '0;
         ydim      <= '0;
         x_lock    <= 1'b0;
         go        <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         go   <= 1'b0;
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               if (bus.start) begin
                  n_lat     <= bus.num_frames;
                  err       <= 1'b0;
                  frame_idx <= '0;
                  busy      <= 1'b1;
                  xdim      <= '0;
                  ydim      <= '0;
                  x_lock    <= 1'b0;
                  state     <= (bus.num_frames == '0) ? FINISH : SYNC;
               end
            end
            SYNC, MEASURE: begin
               if ((state == MEASURE) && vrise) begin
                  if ((xdim == '0) || (ydim == '0)) begin
                     err   <= 1'b1;
                     state <= FINISH;
                  end else begin
                     state <= ARM;
                  end
               end else if ((state == MEASURE) || vfall) begin
                  state <= MEASURE;
                  if (active) begin
                     if (!x_lock)
                        xdim <= (xdim == '1) ? xdim : xdim + 1'b1;
                     if (line_cnt == '0)
                        ydim <= (ydim == '1) ? ydim : ydim + 1'b1;
                  end
                  if (line_end && (xdim != '0))
                     x_lock <= 1'b1;
               end
            end
            ARM: begin
               if (vfall) begin
                  state <= CAPTURE;
                  go    <= 1'b1;
               end
            end
            CAPTURE: begin
               if (line_end && (line_cnt != xdim))
                  err <= 1'b1;
               if (vrise) begin
                  frame_idx <= frame_nxt;
                  state     <= (frame_nxt == n_lat) ? FINISH : ARM;
               end
            end
            FINISH: begin
               // frame_idx is non-zero only when FINISH follows a completed capture.
               go    <= (frame_idx != '0);
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.go        = go;
   assign bus.wr_en     = wr_en;
   assign bus.r_out     = r_out;
   assign bus.g_out     = g_out;
   assign bus.b_out     = b_out;
   assign bus.xdim      = xdim;
   assign bus.ydim      = ydim;
   assign bus.frame_idx = frame_idx;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;

endmodule

// File: tb/tb_vga_frame_capture_ctl.sv
// Directed bench for vga_frame_capture_ctl on a synthetic 12x6 total / 8x4 active raster.
module tb_vga_frame_capture_ctl;

   localparam int NONE = 1000;
   localparam int NV   = 7;

   typedef struct {
      int nf;
      int start_v;
      int start_h;
      bit restart;
      int short_rel;
      int blank_rel;
      int ex_x;
      int ex_y;
      int ex_go;
      int ex_wr;
      int ex_fi;
      bit ex_err;
   } vec_t;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   vga_frame_capture_ctl_if #(.CNT_W(16), .FRM_W(8)) bus ();

   vga_frame_capture_ctl #(.CNT_W(16), .FRM_W(8)) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   int          errors = 0;
   int          checks = 0;
   int          gh = 0;
   int          gv = 4;
   int          gframe = 0;
   int          cyc = 0;
   int          cur_base = 0;
   int          cur_short = NONE;
   int          cur_blank = NONE;
   int          n_go = 0;
   int          n_wr = 0;
   int          n_done = 0;
   logic        rst_drv = 1'b1;
   logic        pend_start = 1'b0;
   logic [7:0]  nf_drv = '0;
   logic [23:0] dly0 = '0;
   logic [23:0] dly1 = '0;
   vec_t        vecs[NV];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic observe();
      if (bus.go) n_go++;
      if (bus.done) n_done++;
      if (bus.wr_en) begin
         n_wr++;
         chk("pix", {bus.r_out, bus.g_out, bus.b_out}, dly1);
      end
   endtask

   task automatic drive_pix();
      int rel;
      rel = gframe - cur_base;
      bus.vblnk = (gv >= 4);
      bus.hblnk = (gh >= 8) || (rel == cur_blank) || (rel == cur_short && gv == 1 && gh == 7);
      bus.r_in  = 8'(cyc);
      bus.g_in  = 8'(cyc) ^ 8'h5A;
      bus.b_in  = {4'(gh), 4'(gv)};
      dly0      = {bus.r_in, bus.g_in, bus.b_in};
      cyc++;
      gh++;
      if (gh == 12) begin
         gh = 0;
         gv++;
         if (gv == 6) begin
            gv = 0;
            gframe++;
         end
      end
   endtask

   task automatic tick();
      @(negedge pclk);
      observe();
      dly1           = dly0;
      rst            = rst_drv;
      bus.start      = pend_start;
      pend_start     = 1'b0;
      bus.num_frames = nf_drv;
      drive_pix();
   endtask

   task automatic align(input int v, input int h);
      int budget;
      budget = 200;
      while (!(gv == v && gh == h) && budget > 0) begin
         tick();
         budget--;
      end
      chk("align_timeout", (budget > 0), 1);
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      int  budget;
      bit  restarted;
      string tag;
      tag = $sformatf("v%0d", idx);
      align(t.start_v, t.start_h);
      cur_base   = gframe + 1;
      cur_short  = t.short_rel;
      cur_blank  = t.blank_rel;
      nf_drv     = 8'(t.nf);
      pend_start = 1'b1;
      n_go = 0; n_wr = 0; n_done = 0;
      tick();
      tick();
      chk({tag, "_busy_on"}, bus.busy, 1);
      chk({tag, "_err_clr"}, bus.err, 0);
      restarted = 1'b0;
      budget = (t.nf + 2) * 72 + 100;
      while (n_done == 0 && budget > 0) begin
         if (t.restart && !restarted && (gframe - cur_base) == 1 && gv == 2 && gh == 0) begin
            pend_start = 1'b1;
            nf_drv     = 8'd5;
            restarted  = 1'b1;
         end
         tick();
         budget--;
      end
      chk({tag, "_done_timeout"}, (budget > 0), 1);
      repeat (8) tick();
      chk({tag, "_xdim"}, bus.xdim, t.ex_x);
      chk({tag, "_ydim"}, bus.ydim, t.ex_y);
      chk({tag, "_go_cnt"}, n_go, t.ex_go);
      chk({tag, "_wr_cnt"}, n_wr, t.ex_wr);
      chk({tag, "_done_cnt"}, n_done, 1);
      chk({tag, "_frame_idx"}, bus.frame_idx, t.ex_fi);
      chk({tag, "_err"}, bus.err, t.ex_err);
      chk({tag, "_busy_off"}, bus.busy, 0);
      cur_short = NONE;
      cur_blank = NONE;
   endtask

   initial begin
      //          nf v  h  rs short blank x  y  go wr  fi err
      vecs[0] = '{2, 5, 0, 0, NONE, NONE, 8, 4, 3, 64, 2, 0};
      vecs[1] = '{2, 5, 0, 0, 2,    NONE, 8, 4, 3, 63, 2, 1};
      vecs[2] = '{1, 5, 0, 0, NONE, NONE, 8, 4, 2, 32, 1, 0};
      vecs[3] = '{3, 5, 0, 0, NONE, 0,    0, 0, 0, 0,  0, 1};
      vecs[4] = '{0, 5, 0, 0, NONE, NONE, 0, 0, 0, 0,  0, 0};
      vecs[5] = '{2, 1, 3, 1, NONE, NONE, 8, 4, 3, 64, 2, 0};
      vecs[6] = '{3, 5, 0, 0, 1,    NONE, 8, 4, 4, 95, 3, 1};

      bus.start = 1'b0;
      bus.num_frames = '0;
      bus.vblnk = 1'b1;
      bus.hblnk = 1'b1;
      bus.r_in = '0;
      bus.g_in = '0;
      bus.b_in = '0;

      rst_drv = 1'b1;
      repeat (4) tick();
      rst_drv = 1'b0;
      tick();
      chk("rst_go", bus.go, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_dims", {bus.xdim, bus.ydim, bus.frame_idx}, 0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // zero-frame request: busy for two cycles, done in the second
      align(5, 0);
      nf_drv = 8'd0;
      pend_start = 1'b1;
      n_go = 0; n_wr = 0;
      tick();
      tick();
      chk("z_busy1", bus.busy, 1);
      chk("z_done1", bus.done, 0);
      tick();
      chk("z_busy2", bus.busy, 1);
      chk("z_done2", bus.done, 1);
      tick();
      chk("z_busy3", bus.busy, 0);
      chk("z_done3", bus.done, 0);
      chk("z_go_wr", n_go + n_wr, 0);

      // reset in the middle of the second captured frame
      align(5, 0);
      cur_base = gframe + 1;
      nf_drv = 8'd2;
      pend_start = 1'b1;
      begin
         int budget;
         budget = 400;
         tick();
         while (!((gframe - cur_base) == 2 && gv == 1 && gh == 0) && budget > 0) begin
            tick();
            budget--;
         end
         chk("mid_timeout", (budget > 0), 1);
      end
      chk("mid_busy", bus.busy, 1);
      rst_drv = 1'b1;
      tick();
      rst_drv = 1'b0;
      tick();
      chk("mrst_ctl", {bus.go, bus.wr_en, bus.busy, bus.done, bus.err}, 0);
      chk("mrst_pix", {bus.r_out, bus.g_out, bus.b_out}, 0);
      chk("mrst_dims", {bus.xdim, bus.ydim, bus.frame_idx}, 0);
      n_go = 0; n_wr = 0; n_done = 0;
      repeat (160) tick();
      chk("mrst_quiet_go", n_go, 0);
      chk("mrst_quiet_wr", n_wr, 0);
      chk("mrst_quiet_done", n_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
